// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Optional hold limit is controlled by the RR_HOLD_LIMIT_EN macro (see rr_mux_arbiter).
package rr_mux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_e;

  localparam int unsigned RR_DEF_N        = 4;
  localparam int unsigned RR_DEF_MAX_HOLD = 8;

  // Widest requester bank the search helper supports.
  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Round-robin search: first set request upward from (ptr+1) mod n, wrapping.
  function automatic rr_pick_t rr_next(input logic [RR_MAX_N-1:0] req,
                                       input int unsigned         ptr,
                                       input int unsigned         n);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
      if (k <= n) begin
        j = (ptr + k) % n;
        if (!res.found && req[j[RR_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/any_mux.sv
// Parameterized N:1 single-bit mux; out-of-range selects yield 0.
module ANY_MUX #(
  parameter int unsigned N = 4,
  parameter int unsigned P = $clog2(N)
) (
  input  logic [N-1:0] I,
  input  logic [P-1:0] S,
  output logic         Y
);

  // Select one input bit by index.
  always_comb begin
    Y = 1'b0;
    if (32'(S) < N) Y = I[S];
  end

endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin priority search starting after the current pointer.
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int unsigned N = RR_DEF_N,
  parameter int unsigned P = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [P-1:0] i_ptr,
  output logic         o_found,
  output logic [P-1:0] o_idx
);

  logic [RR_MAX_N-1:0] w_req_ext;
  rr_pick_t            w_res;

  // Widen the request vector and run the shared search helper.
  always_comb begin
    w_req_ext = RR_MAX_N'(i_req);
    w_res     = rr_next(w_req_ext, 32'(i_ptr), N);
    o_found   = w_res.found;
    o_idx     = P'(w_res.idx);
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an N:1 bit mux under a valid/ready handshake.
// Macro RR_HOLD_LIMIT_EN: when defined, a grant releases after MAX_HOLD beats;
// when undefined, a grant releases only when the holder drops its request.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned N        = RR_DEF_N,
  parameter int unsigned P        = $clog2(N),
  parameter int unsigned MAX_HOLD = RR_DEF_MAX_HOLD,
  parameter int unsigned HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] din,
  output logic [N-1:0] gnt,
  output logic [P-1:0] sel,
  output logic         dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy
);

  if (N < 2 || N > RR_MAX_N) begin : g_bad_n
    $error("rr_mux_arbiter: N out of supported range");
  end
  if (MAX_HOLD < 1 || HW < 1) begin : g_bad_hold
    $error("rr_mux_arbiter: MAX_HOLD must be >= 1");
  end

  rr_state_e    r_state, w_state_nxt;
  logic [N-1:0] r_gnt,   w_gnt_nxt;
  logic [P-1:0] r_sel,   w_sel_nxt;
  logic [P-1:0] r_ptr,   w_ptr_nxt;
  logic         w_found;
  logic [P-1:0] w_win;
  logic         w_holder_req;
  logic         w_release;
`ifdef RR_HOLD_LIMIT_EN
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          w_beat;
`else
  // Acceptance has no effect on grant lifetime without the hold limit.
  logic w_unused_ready;
  assign w_unused_ready = dout_ready;
`endif

  rr_pick #(.N(N), .P(P)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  ANY_MUX #(.N(N), .P(P)) u_mux (
    .I (din),
    .S (r_sel),
    .Y (dout)
  );

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = (r_state == GRANT);

  // Handshake, release decision and next-state selection.
  always_comb begin
    w_holder_req = req[r_sel];
    dout_valid   = (r_state == GRANT) && w_holder_req;
`ifdef RR_HOLD_LIMIT_EN
    w_beat       = dout_valid && dout_ready;
    w_release    = !w_holder_req || (w_beat && (r_hold == HW'(MAX_HOLD - 1)));
    w_hold_nxt   = r_hold;
`else
    w_release    = !w_holder_req;
`endif
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_sel_nxt    = r_sel;
    w_ptr_nxt    = r_ptr;
    // A released holder still sits at ptr, so it naturally gets lowest priority.
    if ((r_state == IDLE) || w_release) begin
      if (w_found) begin
        w_state_nxt = GRANT;
        w_gnt_nxt   = N'(1) << w_win;
        w_sel_nxt   = w_win;
        w_ptr_nxt   = w_win;
      end else begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_sel_nxt   = '0;
      end
`ifdef RR_HOLD_LIMIT_EN
      w_hold_nxt = '0;
    end else if (w_beat) begin
      w_hold_nxt = r_hold + HW'(1);
`endif
    end
  end

  // State, grant, select and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= P'(N - 1);
`ifdef RR_HOLD_LIMIT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef RR_HOLD_LIMIT_EN
      r_hold  <= w_hold_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: N=4 and N=3 instances share stimulus and are
// compared against a behavioural grant model each cycle.
module tb_rr_mux_arbiter;

  localparam int MH = 8;
`ifdef RR_HOLD_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, din;
  logic       dout_ready;

  logic [3:0] gnt4;
  logic [1:0] sel4;
  logic       dout4, dv4, busy4;
  logic [2:0] gnt3;
  logic [1:0] sel3;
  logic       dout3, dv3, busy3;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(4), .MAX_HOLD(MH)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt4), .sel(sel4),
    .dout(dout4), .dout_valid(dv4), .dout_ready(dout_ready), .busy(busy4)
  );

  rr_mux_arbiter #(.N(3), .MAX_HOLD(MH)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req[2:0]), .din(din[2:0]), .gnt(gnt3), .sel(sel3),
    .dout(dout3), .dout_valid(dv3), .dout_ready(dout_ready), .busy(busy3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model state per instance: current holder (-1 = none), RR pointer, beats taken.
  int m_n[2]      = '{4, 3};
  int m_holder[2];
  int m_ptr[2];
  int m_beats[2];

  function automatic int rr_winner(input int d, input logic [3:0] r);
    for (int k = 1; k <= m_n[d]; k++) begin
      int j;
      j = (m_ptr[d] + k) % m_n[d];
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_holder[d] = -1;
      m_ptr[d]    = m_n[d] - 1;
      m_beats[d]  = 0;
    end
  endtask

  task automatic model_step(input logic rs, input logic [3:0] r, input logic rdy);
    for (int d = 0; d < 2; d++) begin
      if (!rs) begin
        m_holder[d] = -1;
        m_ptr[d]    = m_n[d] - 1;
        m_beats[d]  = 0;
      end else begin
        bit take_new;
        take_new = (m_holder[d] < 0);
        if (m_holder[d] >= 0) begin
          if (!r[m_holder[d]]) begin
            take_new = 1'b1;
          end else if (rdy) begin
            m_beats[d]++;
            if (LIM && m_beats[d] == MH) take_new = 1'b1;
          end
        end
        if (take_new) begin
          int w;
          w = rr_winner(d, r);
          m_holder[d] = w;
          m_beats[d]  = 0;
          if (w >= 0) m_ptr[d] = w;
        end
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic [3:0] g;
    logic [1:0] s;
    logic       dv, dt, bz;
    for (int d = 0; d < 2; d++) begin
      int h;
      h  = m_holder[d];
      g  = (d == 0) ? gnt4 : {1'b0, gnt3};
      s  = (d == 0) ? sel4 : sel3;
      dv = (d == 0) ? dv4 : dv3;
      dt = (d == 0) ? dout4 : dout3;
      bz = (d == 0) ? busy4 : busy3;
      check($sformatf("%s N%0d gnt", tag, m_n[d]), 32'(g), (h < 0) ? 32'd0 : (32'd1 << h));
      check($sformatf("%s N%0d busy", tag, m_n[d]), 32'(bz), 32'(h >= 0));
      check($sformatf("%s N%0d valid", tag, m_n[d]), 32'(dv), 32'((h >= 0) && req[h]));
      if (h >= 0) begin
        check($sformatf("%s N%0d sel", tag, m_n[d]), 32'(s), 32'(h));
        if (req[h]) check($sformatf("%s N%0d dout", tag, m_n[d]), 32'(dt), 32'(din[h]));
      end
    end
  endtask

  // Called just after a rising edge: apply inputs, check mid-cycle, advance past the next edge.
  task automatic cycle(input string tag, input logic rs, input logic [3:0] r,
                       input logic [3:0] d, input logic rdy);
    rst_n      = rs;
    req        = r;
    din        = d;
    dout_ready = rdy;
    #3;
    compare_outputs(tag);
    model_step(rs, r, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rq;
    rst_n = 1'b0; req = 4'b1111; din = '0; dout_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Reset with all requests high.
    repeat (2) cycle("reset", 1'b0, 4'b1111, 4'b0000, 1'b1);
    check("reset sel", 32'(sel4), 32'd0);
    cycle("rst_rel", 1'b1, 4'b1111, 4'b0101, 1'b1);
    check("rst_rel first gnt", 32'(gnt4), 32'h1);

    // Fairness / hold behaviour with everyone requesting.
    repeat (40) cycle("fair", 1'b1, 4'b1111, 4'($urandom), 1'b1);

    // Single requester then drop.
    cycle("single_rst", 1'b0, 4'b0000, 4'b0000, 1'b1);
    repeat (4) cycle("single", 1'b1, 4'b0100, 4'b0100, 1'b1);
    check("single sel", 32'(sel4), 32'd2);
    check("single dout", 32'(dout4), 32'd1);
    repeat (2) cycle("drop", 1'b1, 4'b0000, 4'b0100, 1'b1);
    check("drop gnt", 32'(gnt4), 32'd0);

    // Backpressure while index 1 holds the grant.
    cycle("bp_rst", 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle("bp_arb", 1'b1, 4'b0010, 4'b0010, 1'b1);
    repeat (2) cycle("bp_go", 1'b1, 4'b1111, 4'($urandom), 1'b1);
    repeat (5) cycle("bp_stall", 1'b1, 4'b1111, 4'($urandom), 1'b0);
    check("bp stall gnt", 32'(gnt4), 32'h2);
    repeat (12) cycle("bp_resume", 1'b1, 4'b1111, 4'($urandom), 1'b1);

    // Reset in the middle of a burst to index 3.
    cycle("mid_rst0", 1'b0, 4'b0000, 4'b0000, 1'b1);
    repeat (5) cycle("mid_burst", 1'b1, 4'b1000, 4'($urandom), 1'b1);
    cycle("mid_rst", 1'b0, 4'b1000, 4'b0000, 1'b1);
    check("mid_rst gnt", 32'(gnt4), 32'd0);
    repeat (3) cycle("mid_after", 1'b1, 4'b0110, 4'($urandom), 1'b1);

    // Wrap from ptr=N-1 on the three-requester instance.
    cycle("wrap_rst", 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle("wrap_arb", 1'b1, 4'b0101, 4'($urandom), 1'b1);
    check("wrap N3 gnt", 32'(gnt3), 32'h1);
    repeat (20) cycle("wrap", 1'b1, 4'b0101, 4'($urandom), 1'b1);

    // Randomized level-held requests, random backpressure, rare resets.
    rq = 4'($urandom);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      cycle("rand", ($urandom_range(0, 299) != 0), rq, 4'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the team's parameterized N:1 bit mux (ANY_MUX).
- N requesters share one serial output channel. The arbiter picks a requester, drives the mux select, and forwards that requester's data bit under a valid/ready handshake.
- A burst-hold limit stops any one requester from starving the others.
- Sits between the requester bank and the single downstream consumer.

Parameters:
- N, 4, number of requesters (N >= 2; need not be a power of two).
- P, $clog2(N), select width.
- MAX_HOLD, 8, maximum consecutive beats per grant (>= 1).
- HW, $clog2(MAX_HOLD+1), hold-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  N  per-requester request; level-held while the requester has data.
- din  in  N  per-requester data bit; mux input I.
- gnt  out  N  one-hot grant, registered.
- sel  out  P  mux select, registered; always equals the index of the set gnt bit.
- dout  out  1  din[sel] through the mux.
- dout_valid  out  1  beat valid.
- dout_ready  in  1  downstream accept.
- busy  out  1  high in GRANT state.

Behaviour:
- One clock. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, gnt=0, sel=0, busy=0, hold_cnt=0, ptr=N-1 (first search starts at index 0).
  - dout_valid=0 while in IDLE.
  - dout is don't-care when dout_valid=0.
- States:
  - IDLE: gnt=0. If |req, run the RR pick and load gnt/sel/ptr; go to GRANT next cycle. This gives 1-cycle arbitration latency from req to gnt.
  - GRANT:
    - dout_valid = req[sel] (combinational), dout = din[sel].
    - Beat = dout_valid && dout_ready. Each beat increments hold_cnt.
- RR pick: search upward from (ptr+1) mod N, wrapping. The first set req wins; ptr is updated to the winner. The current holder therefore has the lowest priority.
- Release of the grant happens when either:
  - req[sel]=0 (requester dropped; no beat that cycle), or
  - a beat occurs with hold_cnt==MAX_HOLD-1.
- On release:
  - If any req is set (excluding a dropped holder), re-arbitrate in the same cycle and move GRANT->GRANT with the new gnt next cycle. hold_cnt clears to 0. No idle bubble.
  - Otherwise go to IDLE, with gnt=0 next cycle.
  - A hold-limited holder that is the only requester is re-granted with hold_cnt=0.
- Stall: dout_ready=0 while dout_valid=1 means no beat. hold_cnt, gnt and sel hold; dout tracks din[sel].
- Simultaneous requests: resolved purely by RR order from ptr+1.
- New requests arriving during a grant are not serviced until release.
- sel never exceeds N-1 for non-power-of-two N.
- Reset mid-burst: at the next edge with rst_n=0, all state returns to reset values, gnt drops, and no beat is counted that cycle.

Optional Feature:
- Macro: RR_HOLD_LIMIT_EN.
- Defined: MAX_HOLD limit enforced as above.
- Undefined:
  - hold_cnt logic is removed.
  - Grant releases only when req[sel] drops.
  - MAX_HOLD is ignored.

Decomposition:
- Package rr_mux_pkg holds:
  - state encoding (IDLE=1'b0, GRANT=1'b1);
  - a localparam for default N/MAX_HOLD;
  - function rr_next(req, ptr) returning the winner index and a found flag.
- One natural sub-module, rr_pick: combinational round-robin priority search from ptr+1. It is instantiated once.
- The datapath is an ANY_MUX #(N,P) instance driven by sel.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with req=4'b1111 -> gnt=0, sel=0, dout_valid=0, busy=0. After release, gnt=4'b0001 one cycle later.
- Single requester: req=4'b0100, din=4'b0100, dout_ready=1 -> gnt=4'b0100, sel=2, dout=1, dout_valid=1. Drop req -> IDLE and gnt=0 next cycle.
- Fairness: req=4'b1111 held, dout_ready=1, MAX_HOLD=8 -> grant order 0,1,2,3,0, each held exactly 8 beats, no bubble between grants. Without RR_HOLD_LIMIT_EN -> index 0 holds indefinitely.
- Backpressure: while granted to index 1, dout_ready=0 for 5 cycles -> gnt and sel stable, hold_cnt frozen. After dout_ready returns, the remaining beats complete the hold of 8.
- Wrap and non-power-of-two N: N=3, ptr=2, req=3'b101 -> gnt=3'b001. Next release with req=3'b101 -> gnt=3'b100. sel never reaches 3.
- Reset mid-burst: rst_n=0 for one edge at beat 4 of a grant to index 3 -> gnt=0 next cycle. Then the first grant after reset goes to the lowest set req index.
